dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-port data RAM between two requesters: port 0 is the CPU load/store path and port 1 is the debug/DMA loader.
- Sits between the requesters and the data memory, driving its write_enable, address and write_data, and receiving its combinational read_data.
- Uses round-robin arbitration with optional locked bursts capped at BURST_MAX beats.
- Registered grant and registered read return.

Parameters:
- ADDR_W, 8, address width of the RAM and both ports.
- DATA_W, 8, data width.
- BURST_MAX, 4, maximum consecutive locked beats per grant when the other port is waiting (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req0  input  1  port 0 access request.
- lock0  input  1  port 0 wants another beat after the current one.
- we0  input  1  port 0 write (1) or read (0).
- addr0  input  ADDR_W  port 0 address.
- wdata0  input  DATA_W  port 0 write data.
- gnt0  output  1  port 0 beat performed this cycle.
- rdata0  output  DATA_W  port 0 read data (registered).
- rvalid0  output  1  one-cycle pulse; rdata0 valid.
- req1, lock1, we1, addr1, wdata1, gnt1, rdata1, rvalid1: same as port 0, for port 1.
- mem_we  output  1  RAM write enable.
- mem_addr  output  ADDR_W  RAM address.
- mem_wdata  output  DATA_W  RAM write data.
- mem_rdata  input  DATA_W  RAM combinational read data.
- busy  output  1  high when state != IDLE.

Behaviour:
- FSM states: IDLE, OWN0, OWN1. gnt0 = (state==OWN0); gnt1 = (state==OWN1).
- Reset (reset_n low, asynchronous):
  - State goes to IDLE, beat_cnt to 0, last_owner to 1 (port 0 wins the first tie).
  - All outputs go to 0, including rdata0/1, rvalid0/1, mem_* and busy.
- Requester protocol: hold req/we/addr/wdata stable from req assertion until a cycle with gnt high. Each gnt-high cycle is exactly one beat.
- Beat in OWNx:
  - mem_addr = addrx and mem_wdata = wdatax (combinational mux).
  - mem_we = wex & reqx.
  - Write commits at the clock edge that ends the cycle.
  - Read: if reqx & !wex, rdatax <= mem_rdata and rvalidx pulses high for the following cycle.
- Latency: req rises before edge k -> gnt during cycle k+1 -> write committed at edge k+2, or rdata/rvalid during cycle k+2.
- Outside a beat: mem_we = 0 and mem_addr/mem_wdata hold their last values. Unused rdata keeps its last value.
- IDLE transitions:
  - Only req0 -> OWN0. Only req1 -> OWN1.
  - Both -> the port != last_owner.
  - Neither -> stay IDLE.
- OWNx transitions, evaluated at the end of each beat:
  - lockx & reqx & (beat_cnt < BURST_MAX-1) -> stay in OWNx, beat_cnt++.
  - lockx & reqx & beat_cnt == BURST_MAX-1 & other req low -> stay, beat_cnt = 0 (no pre-emption without contention).
  - lockx & reqx & beat_cnt == BURST_MAX-1 & other req high -> OWN_other (forced release).
  - Otherwise -> OWN_other if other req high, else IDLE.
  - On any exit from OWNx: last_owner = x and beat_cnt = 0.
- reqx low while in OWNx (protocol violation): no write, no rvalid; release as above.
- Simultaneous release and new request from the same port: that port goes through IDLE, costing one bubble cycle. No back-to-back unlocked grants to the same port.
- Reset asserted mid-burst: the in-flight beat is aborted and the write is not committed if reset lands before the edge. Resumes from IDLE.
- Starvation bound: a waiting port is granted within BURST_MAX+1 cycles.

Optional Feature:
- Macro: DMEM_ARB_PRIO0_EN.
- Defined:
  - Port 0 (CPU) has fixed priority: both requesting in IDLE -> OWN0 regardless of last_owner.
  - OWN1 releases to OWN0 after its current beat whenever req0 is high, ignoring lock1 and BURST_MAX.
  - Port 0 locked bursts are never pre-empted.
- Undefined: round-robin behaviour exactly as in Behaviour.

Test Plan:
- Reset then single write: req0=1, we0=1, addr0=0x10, wdata0=0xA5 -> gnt0 high one cycle later with mem_we=1, mem_addr=0x10. A later port-1 read of 0x10 returns rdata1=0xA5 with a one-cycle rvalid1 pulse.
- Simultaneous request after reset: req0=req1=1 (reads) -> gnt0 first, then gnt1 on the next cycle, then IDLE. busy high for exactly 2 cycles.
- Locked burst with contention, BURST_MAX=4:
  - Port 1 holds lock1=1 and writes 0x20..0x27 while req0=1 throughout.
  - Expect gnt1 for 4 cycles, then gnt0 for 1, then gnt1 resumes at 0x24.
- Locked burst without contention: port 1 runs 6 locked beats with req0=0 -> gnt1 continuous for 6 cycles, no bubbles.
- Abort: assert reset_n=0 during the 2nd beat of a port-0 write burst, before the clock edge -> that address is unchanged, all outputs 0, next req1 is granted first.
- With DMEM_ARB_PRIO0_EN: during a port-1 locked burst, raise req0 -> gnt0 follows the current gnt1 beat within 1 cycle, and port 1 resumes afterwards.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester handshakes for both ports plus the RAM-side bus of dmem_arbiter.
// The slave modport is the arbiter's view; master is the requesters/RAM environment.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req0;
  logic              lock0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0;
  logic [DATA_W-1:0] rdata0;
  logic              rvalid0;

  logic              req1;
  logic              lock1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt1;
  logic [DATA_W-1:0] rdata1;
  logic              rvalid1;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  req0, lock0, we0, addr0, wdata0,
    input  req1, lock1, we1, addr1, wdata1,
    input  mem_rdata,
    output gnt0, rdata0, rvalid0,
    output gnt1, rdata1, rvalid1,
    output mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output req0, lock0, we0, addr0, wdata0,
    output req1, lock1, we1, addr1, wdata1,
    output mem_rdata,
    input  gnt0, rdata0, rvalid0,
    input  gnt1, rdata1, rvalid1,
    input  mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the CPU (port 0) and the debug/DMA loader (port 1).
// Round-robin with locked bursts capped at BURST_MAX; define DMEM_ARB_PRIO0_EN to give port 0 fixed priority.
module dmem_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int BURST_MAX = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  dmem_arbiter_if.slave bus
);

  localparam int CNT_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(BURST_MAX - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  logic [1:0]        state, state_nxt;
  logic [CNT_W-1:0]  beat_cnt, cnt_nxt;
  logic              last_owner, last_nxt;
  logic [ADDR_W-1:0] addr_hold;
  logic [DATA_W-1:0] wdata_hold;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              rvalid0_q, rvalid1_q;

  logic              own_req, own_lock, own_we, other_req;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata;
  logic              in_beat, rd_beat, at_cap, want_more, stay;

  // Select the owning port's request; outside a beat the RAM bus holds its last values.
  always_comb begin
    own_req   = 1'b0;
    own_lock  = 1'b0;
    own_we    = 1'b0;
    other_req = 1'b0;
    own_addr  = addr_hold;
    own_wdata = wdata_hold;
    case (state)
      OWN0: begin
        own_req   = bus.req0;
        own_lock  = bus.lock0;
        own_we    = bus.we0;
        other_req = bus.req1;
        own_addr  = bus.addr0;
        own_wdata = bus.wdata0;
      end
      OWN1: begin
        own_req   = bus.req1;
        own_lock  = bus.lock1;
        own_we    = bus.we1;
        other_req = bus.req0;
        own_addr  = bus.addr1;
        own_wdata = bus.wdata1;
      end
      default: ;
    endcase
  end

  assign in_beat   = (state == OWN0) || (state == OWN1);
  assign rd_beat   = in_beat && own_req && !own_we;
  assign at_cap    = (beat_cnt == CNT_CAP);
  assign want_more = own_lock && own_req;

  // A locked beat keeps the grant unless the burst cap is reached while the other port waits.
`ifdef DMEM_ARB_PRIO0_EN
  assign stay = want_more && ((state == OWN0) || !other_req);
`else
  assign stay = want_more && (!at_cap || !other_req);
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = beat_cnt;
    last_nxt  = last_owner;
    if (state == IDLE) begin
      cnt_nxt = '0;
      if (bus.req0 && bus.req1) begin
`ifdef DMEM_ARB_PRIO0_EN
        state_nxt = OWN0;
`else
        state_nxt = last_owner ? OWN0 : OWN1;
`endif
      end else if (bus.req0) begin
        state_nxt = OWN0;
      end else if (bus.req1) begin
        state_nxt = OWN1;
      end
    end else if (stay) begin
      cnt_nxt = at_cap ? '0 : beat_cnt + CNT_W'(1);
    end else begin
      cnt_nxt   = '0;
      last_nxt  = (state == OWN1);
      state_nxt = !other_req ? IDLE : ((state == OWN0) ? OWN1 : OWN0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      last_owner <= 1'b1;
      addr_hold  <= '0;
      wdata_hold <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      state      <= state_nxt;
      beat_cnt   <= cnt_nxt;
      last_owner <= last_nxt;
      addr_hold  <= own_addr;
      wdata_hold <= own_wdata;
      rvalid0_q  <= rd_beat && (state == OWN0);
      rvalid1_q  <= rd_beat && (state == OWN1);
      if (rd_beat && (state == OWN0)) rdata0_q <= bus.mem_rdata;
      if (rd_beat && (state == OWN1)) rdata1_q <= bus.mem_rdata;
    end
  end

  assign bus.gnt0      = (state == OWN0);
  assign bus.gnt1      = (state == OWN1);
  assign bus.busy      = (state != IDLE);
  assign bus.mem_we    = in_beat && own_we && own_req;
  assign bus.mem_addr  = own_addr;
  assign bus.mem_wdata = own_wdata;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.rvalid0   = rvalid0_q;
  assign bus.rvalid1   = rvalid1_q;

endmodule
